// File: rtl/reflet_float_fisqrt_arbiter_if.sv
// Request/response and shared fisqrt-unit signals of the arbiter.
// slave = arbiter side, master = requesters plus the fisqrt unit.
interface reflet_float_fisqrt_arbiter_if #(
  parameter int float_size = 32,
  parameter int requesters = 4
);
  logic [requesters-1:0]            req_valid;
  logic [requesters*float_size-1:0] req_data;
  logic [requesters-1:0]            req_ready;
  logic [requesters-1:0]            resp_valid;
  logic [requesters-1:0]            resp_ready;
  logic [float_size-1:0]            resp_data;
  logic [$clog2(requesters)-1:0]    grant_id;
  logic                             busy;
  logic                             fisqrt_enable;
  logic [float_size-1:0]            fisqrt_in;
  logic [float_size-1:0]            fisqrt_out;
  logic                             fisqrt_ready;

  modport slave (
    input  req_valid, req_data, resp_ready, fisqrt_out, fisqrt_ready,
    output req_ready, resp_valid, resp_data, grant_id, busy, fisqrt_enable, fisqrt_in
  );

  modport master (
    output req_valid, req_data, resp_ready, fisqrt_out, fisqrt_ready,
    input  req_ready, resp_valid, resp_data, grant_id, busy, fisqrt_enable, fisqrt_in
  );
endinterface

// File: rtl/reflet_float_fisqrt_arbiter.sv
// Round-robin sharing of one fisqrt unit: accept in IDLE, RUN until unit ready, RESP held until the owner consumes it.
// Result k+1 cycles after acceptance; REFLET_FLOAT_FISQRT_ARB_SPECIAL_EN answers +-0 / negative operands directly in RESP.
module reflet_float_fisqrt_arbiter #(
  parameter int float_size = 32,
  parameter int requesters = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  reflet_float_fisqrt_arbiter_if.slave bus
);
  localparam int GW = $clog2(requesters);
`ifdef REFLET_FLOAT_FISQRT_ARB_SPECIAL_EN
  localparam int EXP_W  = (float_size == 16) ? 5 : (float_size == 32) ? 8 : 11;
  localparam int MANT_W = float_size - 1 - EXP_W;
`endif

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [GW-1:0]          grant_id_q, grant_id_d;
  logic [float_size-1:0]  operand_q, operand_d;
  logic [float_size-1:0]  resp_data_q, resp_data_d;
  logic [requesters-1:0]  resp_valid_q, resp_valid_d;
  logic                   fisqrt_enable_q, fisqrt_enable_d;
  logic                   busy_q, busy_d;

  logic                   found;
  logic [GW-1:0]          pick;
  logic [float_size-1:0]  pick_data;
  logic [requesters-1:0]  req_ready_c;
  logic                   special;
  logic [float_size-1:0]  special_res;

  // First pending requester after the last one served.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= requesters; i++) begin
      if (!found && bus.req_valid[(int'(last_grant_q) + i) % requesters]) begin
        found = 1'b1;
        pick  = GW'((int'(last_grant_q) + i) % requesters);
      end
    end
  end

  assign pick_data = bus.req_data[int'(pick)*float_size +: float_size];

  always_comb begin
    special     = 1'b0;
    special_res = '0;
`ifdef REFLET_FLOAT_FISQRT_ARB_SPECIAL_EN
    if (pick_data[float_size-2:0] == '0) begin
      special     = 1'b1;
      special_res = {pick_data[float_size-1], {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (pick_data[float_size-1]) begin
      special     = 1'b1;
      special_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    end
`endif
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_id_d      = grant_id_q;
    operand_d       = operand_q;
    resp_data_d     = resp_data_q;
    resp_valid_d    = resp_valid_q;
    fisqrt_enable_d = fisqrt_enable_q;
    req_ready_c     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_c[pick] = 1'b1;
          operand_d         = pick_data;
          grant_id_d        = pick;
          last_grant_d      = pick;
          if (special) begin
            resp_data_d        = special_res;
            resp_valid_d       = '0;
            resp_valid_d[pick] = 1'b1;
            state_d            = RESP;
          end else begin
            fisqrt_enable_d = 1'b1;
            state_d         = RUN;
          end
        end
      end
      RUN: begin
        if (bus.fisqrt_ready) begin
          resp_data_d              = bus.fisqrt_out;
          fisqrt_enable_d          = 1'b0;
          resp_valid_d             = '0;
          resp_valid_d[grant_id_q] = 1'b1;
          state_d                  = RESP;
        end
      end
      RESP: begin
        // Only the owner's resp_ready can release the result.
        if (bus.resp_ready[grant_id_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d    = '0;
        fisqrt_enable_d = 1'b0;
        state_d         = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      last_grant_q    <= GW'(requesters - 1);
      grant_id_q      <= '0;
      operand_q       <= '0;
      resp_data_q     <= '0;
      resp_valid_q    <= '0;
      fisqrt_enable_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      grant_id_q      <= grant_id_d;
      operand_q       <= operand_d;
      resp_data_q     <= resp_data_d;
      resp_valid_q    <= resp_valid_d;
      fisqrt_enable_q <= fisqrt_enable_d;
      busy_q          <= busy_d;
    end
  end

  // Acceptance is a same-cycle decode so the pulse lands while still in IDLE.
  assign bus.req_ready     = reset ? '0 : req_ready_c;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.busy          = busy_q;
  assign bus.fisqrt_enable = fisqrt_enable_q;
  assign bus.fisqrt_in     = fisqrt_enable_q ? operand_q : '0;
endmodule
